multicycle_ctrl: RTL and testbench

//   Multicycle FSM controller for the RV32I subset datapath. It decodes the

---
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// ============================================================================
// Module   : multicycle_ctrl_if
// Purpose  : Control bundle between the multicycle controller and the datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        ALUSrc;
  logic [3:0]  ALUCtrl;
  logic        RegWrite;
  logic        MemToReg;
  logic        PCSrc;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic        illegal;

  modport master (
    input  instr, Zero,
    output ALUSrc, ALUCtrl, RegWrite, MemToReg, PCSrc, loadPC,
           MemRead, MemWrite, illegal
  );

  modport slave (
    output instr, Zero,
    input  ALUSrc, ALUCtrl, RegWrite, MemToReg, PCSrc, loadPC,
           MemRead, MemWrite, illegal
  );
endinterface

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : IF/ID/EX/MEM/WB sequencer and decoder for the RV32I subset
//            datapath. Optional macro ILLEGAL_TRAP_EN adds a sticky HALT trap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
`ifdef ILLEGAL_TRAP_EN
    S_WB   = 3'd4,
    S_HALT = 3'd5
`else
    S_WB   = 3'd4
`endif
  } state_t;

  typedef enum logic [2:0] {
    K_NOP = 3'd0,
    K_R   = 3'd1,
    K_I   = 3'd2,
    K_LW  = 3'd3,
    K_SW  = 3'd4,
    K_BEQ = 3'd5
  } kind_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;

  kind_t      kind_q;
  logic       src_q;
  logic [3:0] alu_q;

  kind_t      dec_kind;
  logic       dec_src;
  logic [3:0] dec_alu;
  logic       dec_legal;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alt;

  logic       alu_src;
  logic [3:0] alu_ctrl;
  logic       reg_write;
  logic       mem_to_reg;
  logic       pc_src;
  logic       load_pc;
  logic       mem_read;
  logic       mem_write;

  logic       unused_instr_bits;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign alt    = bus.instr[30];

  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // Shared R/I ALU decode: returns {valid, code}; sub_sel only matters for funct3=000.
  function automatic logic [4:0] alu_decode(input logic [2:0] f3,
                                            input logic       sub_sel,
                                            input logic       sra_sel);
    logic [4:0] r;
    r = 5'b0_0000;
    case (f3)
      3'b000:  r = {1'b1, sub_sel ? ALU_SUB : ALU_ADD};
      3'b001:  r = {1'b1, ALU_SLL};
      3'b010:  r = {1'b1, ALU_SLT};
      3'b100:  r = {1'b1, ALU_XOR};
      3'b101:  r = {1'b1, sra_sel ? ALU_SRA : ALU_SRL};
      3'b110:  r = {1'b1, ALU_OR};
      3'b111:  r = {1'b1, ALU_AND};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [4:0] rd;
    dec_kind  = K_NOP;
    dec_src   = 1'b0;
    dec_alu   = ALU_AND;
    dec_legal = 1'b0;
    rd        = 5'b0_0000;
    case (opcode)
      OP_R: begin
        rd        = alu_decode(funct3, alt, alt);
        dec_legal = rd[4];
        dec_kind  = K_R;
        dec_alu   = rd[3:0];
      end
      OP_I: begin
        // ADDI's immediate may set bit 30; only the shift form reads it.
        rd        = alu_decode(funct3, 1'b0, alt);
        dec_legal = rd[4];
        dec_kind  = K_I;
        dec_src   = 1'b1;
        dec_alu   = rd[3:0];
      end
      OP_LW: begin
        dec_legal = (funct3 == 3'b010);
        dec_kind  = K_LW;
        dec_src   = 1'b1;
        dec_alu   = ALU_ADD;
      end
      OP_SW: begin
        dec_legal = (funct3 == 3'b010);
        dec_kind  = K_SW;
        dec_src   = 1'b1;
        dec_alu   = ALU_ADD;
      end
      OP_BEQ: begin
        dec_legal = (funct3 == 3'b000);
        dec_kind  = K_BEQ;
        dec_alu   = ALU_SUB;
      end
      default: dec_legal = 1'b0;
    endcase
    if (!dec_legal) begin
      dec_kind = K_NOP;
      dec_src  = 1'b0;
      dec_alu  = ALU_AND;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IF;
      wait_cnt <= 4'd0;
      kind_q   <= K_NOP;
      src_q    <= 1'b0;
      alu_q    <= ALU_AND;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state == S_ID) begin
        kind_q <= dec_kind;
        src_q  <= dec_src;
        alu_q  <= dec_alu;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state == S_ID && !dec_legal) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    alu_src    = 1'b0;
    alu_ctrl   = ALU_AND;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    load_pc    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (state)
      S_IF: state_nxt = S_ID;
      S_ID: begin
`ifdef ILLEGAL_TRAP_EN
        state_nxt = dec_legal ? S_EX : S_HALT;
`else
        state_nxt = S_EX;
`endif
      end
      S_EX: begin
        alu_src   = src_q;
        alu_ctrl  = alu_q;
        wait_nxt  = 4'd0;
        state_nxt = (kind_q == K_LW || kind_q == K_SW) ? S_MEM : S_WB;
      end
      S_MEM: begin
        alu_src   = src_q;
        alu_ctrl  = alu_q;
        mem_read  = (kind_q == K_LW);
        mem_write = (kind_q == K_SW);
        if (wait_cnt == MEM_LAST) begin
          wait_nxt  = 4'd0;
          state_nxt = S_WB;
        end else begin
          wait_nxt  = wait_cnt + 4'd1;
        end
      end
      S_WB: begin
        alu_src    = src_q;
        alu_ctrl   = alu_q;
        reg_write  = (kind_q == K_R) || (kind_q == K_I) || (kind_q == K_LW);
        mem_to_reg = (kind_q == K_LW);
        pc_src     = (kind_q == K_BEQ) && bus.Zero;
        load_pc    = 1'b1;
        state_nxt  = S_IF;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: state_nxt = S_HALT;
`endif
      default: state_nxt = S_IF;
    endcase
  end

  assign bus.ALUSrc   = alu_src;
  assign bus.ALUCtrl  = alu_ctrl;
  assign bus.RegWrite = reg_write;
  assign bus.MemToReg = mem_to_reg;
  assign bus.PCSrc    = pc_src;
  assign bus.loadPC   = load_pc;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Directed scoreboard bench for multicycle_ctrl (MEM_LAT = 3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int lat;
    int rw;
    int mtr;
    int pcs;
    int src;
    int alu;
    int mr;
    int mw;
    int mwp;
    bit chk_alu;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int out_vec();
    return int'({bus.ALUSrc, bus.ALUCtrl, bus.RegWrite, bus.MemToReg, bus.PCSrc,
                 bus.loadPC, bus.MemRead, bus.MemWrite, bus.illegal});
  endfunction

  // Called at the falling edge of an IF cycle; returns at the next IF cycle.
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic zero,
                           input int lat, input int rw, input int mtr, input int pcs,
                           input int src, input int alu, input int mr, input int mw,
                           input int mwp, input bit chk_alu);
    exp_t e;
    int n = 0, o_rw = 0, o_mr = 0, o_mw = 0, o_mwp = 0;
    int o_src = -1, o_alu = -1, o_alu_wb = -1, o_mtr = -1, o_pcs = -1;
    bit done = 1'b0;
    bit prev_mw = 1'b0;
    e = '{lat, rw, mtr, pcs, src, alu, mr, mw, mwp, chk_alu};
    sb.push_back(e);
    bus.instr = ins;
    bus.Zero  = zero;
    while (!done && n < 40) begin
      n++;
      if (n == 3) begin
        o_src = int'(bus.ALUSrc);
        o_alu = int'(bus.ALUCtrl);
      end
      o_rw += int'(bus.RegWrite);
      o_mr += int'(bus.MemRead);
      o_mw += int'(bus.MemWrite);
      if (bus.MemWrite && !prev_mw) o_mwp++;
      prev_mw = bus.MemWrite;
      if (bus.loadPC) begin
        done     = 1'b1;
        o_mtr    = int'(bus.MemToReg);
        o_pcs    = int'(bus.PCSrc);
        o_alu_wb = int'(bus.ALUCtrl);
      end else begin
        @(negedge clk);
      end
    end
    check({tag, "_done"}, int'(done), 1);
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "_latency"}, n, e.lat);
    check({tag, "_regwrite_cycles"}, o_rw, e.rw);
    check({tag, "_memtoreg_wb"}, o_mtr, e.mtr);
    check({tag, "_pcsrc_wb"}, o_pcs, e.pcs);
    check({tag, "_memread_cycles"}, o_mr, e.mr);
    check({tag, "_memwrite_cycles"}, o_mw, e.mw);
    check({tag, "_memwrite_pulses"}, o_mwp, e.mwp);
    if (e.chk_alu) begin
      check({tag, "_alusrc_ex"}, o_src, e.src);
      check({tag, "_aluctrl_ex"}, o_alu, e.alu);
      check({tag, "_aluctrl_wb"}, o_alu_wb, e.alu);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.instr = 32'h0000_0013;
    bus.Zero  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    rst = 1'b0;

    //        tag      instr         Z  lat rw mtr pcs src alu mr mw mwp chk
    run_instr("add",   32'h002081B3, 0, 4,  1, 0,  0,  0,  2,  0, 0, 0,  1);
    run_instr("lw",    32'h0080A283, 0, 7,  1, 1,  0,  1,  2,  3, 0, 0,  1);
    run_instr("beq_t", 32'h00208863, 1, 4,  0, 0,  1,  0,  6,  0, 0, 0,  1);
    run_instr("beq_f", 32'h00208863, 0, 4,  0, 0,  0,  0,  6,  0, 0, 0,  1);
    run_instr("sw",    32'h0020A223, 1, 7,  0, 0,  0,  1,  2,  0, 3, 1,  1);
    run_instr("sub",   32'h40208133, 1, 4,  1, 0,  0,  0,  6,  0, 0, 0,  1);
    run_instr("slt",   32'h0020A1B3, 0, 4,  1, 0,  0,  0,  4,  0, 0, 0,  1);
    run_instr("srai",  32'h4030D093, 0, 4,  1, 0,  0,  1,  10, 0, 0, 0,  1);
    run_instr("addi",  32'h40000093, 0, 4,  1, 0,  0,  1,  2,  0, 0, 0,  1);

    // Second store aborted by reset while in MEM.
    bus.instr = 32'h0020A223;
    repeat (3) @(negedge clk);
    check("sw_abort_memwrite_in_mem", int'(bus.MemWrite), 1);
    rst = 1'b1;
    @(negedge clk);
    check("sw_abort_outputs_after_rst", out_vec(), 0);
    rst = 1'b0;
    run_instr("add_after_abort", 32'h002081B3, 0, 4, 1, 0, 0, 0, 2, 0, 0, 0, 1);

`ifdef ILLEGAL_TRAP_EN
    begin
      int lpc = 0;
      bus.instr = 32'hFFFF_FFFF;
      bus.Zero  = 1'b1;
      repeat (20) begin
        @(negedge clk);
        lpc += int'(bus.loadPC);
      end
      check("trap_illegal", int'(bus.illegal), 1);
      check("trap_no_loadpc", lpc, 0);
      check("trap_no_strobes", out_vec(), 1);
      rst = 1'b1;
      @(negedge clk);
      check("trap_cleared_by_rst", out_vec(), 0);
      rst = 1'b0;
    end
`else
    run_instr("illegal_nop", 32'hFFFF_FFFF, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("illegal_flag_tied", int'(bus.illegal), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
